// File: rtl/router_pkt_drain.sv
// Read-side drain for one router output FIFO: pops header/payload/parity, streams bytes,
// checks parity and aborts on read timeout. Optional counters under ROUTER_DRAIN_STATS_EN.
module router_pkt_drain #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 30,
    parameter int unsigned CW      = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             empty,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             dst_ready,
    output logic             rd_en,
    output logic             byte_vld,
    output logic [WIDTH-1:0] byte_out,
    output logic             sop,
    output logic             eop,
    output logic [1:0]       pkt_addr,
    output logic [5:0]       pkt_len,
    output logic             pkt_done,
    output logic             parity_err,
    output logic             soft_reset_out
`ifdef ROUTER_DRAIN_STATS_EN
    ,
    output logic [15:0]      pkt_cnt,
    output logic [15:0]      err_cnt,
    output logic [15:0]      tmo_cnt_total
`endif
);

    typedef enum logic [1:0] {StIdle, StHdr, StBody, StDone} state_e;

    state_e           state_q, state_d;
    logic             rd_d_q;
    logic [5:0]       len_q, len_d;
    logic [1:0]       addr_q, addr_d;
    logic [WIDTH-1:0] xor_q, xor_d;
    logic [6:0]       req_cnt_q, req_cnt_d;
    logic [6:0]       cap_cnt_q, cap_cnt_d;
    logic [CW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [WIDTH-1:0] byte_out_q, byte_out_d;
    logic             byte_vld_q, byte_vld_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic             parity_err_q, parity_err_d;
    logic             busy;
    logic             tmo_hit;
    logic             last_cap;

    assign busy     = (state_q == StHdr) || (state_q == StBody);
    // Abort only on a cycle with no capture, so no byte is lost mid-emit.
    assign tmo_hit  = busy && !rd_d_q && (tmo_cnt_q == CW'(TIMEOUT - 1));
    assign last_cap = rd_d_q && (cap_cnt_q == {1'b0, len_q});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (rd_en) state_d = StHdr;
            StHdr: begin
                if (tmo_hit)     state_d = StIdle;
                else if (rd_d_q) state_d = StBody;
            end
            StBody: begin
                if (tmo_hit)       state_d = StIdle;
                else if (last_cap) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_en          = 1'b0;
        pkt_done       = 1'b0;
        soft_reset_out = tmo_hit;
        unique case (state_q)
            StIdle: rd_en = !empty && dst_ready;
            StBody: rd_en = !empty && dst_ready && !tmo_hit &&
                            (req_cnt_q < ({1'b0, len_q} + 7'd1));
            StDone: pkt_done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        len_d        = len_q;
        addr_d       = addr_q;
        xor_d        = xor_q;
        req_cnt_d    = req_cnt_q;
        cap_cnt_d    = cap_cnt_q;
        byte_out_d   = byte_out_q;
        byte_vld_d   = 1'b0;
        sop_d        = 1'b0;
        eop_d        = 1'b0;
        parity_err_d = parity_err_q;
        tmo_cnt_d    = '0;
        if (busy && !rd_d_q && !tmo_hit) tmo_cnt_d = tmo_cnt_q + CW'(1);

        if (state_q == StHdr && rd_d_q) begin
            len_d      = fifo_data[7:2];
            addr_d     = fifo_data[1:0];
            xor_d      = fifo_data;
            byte_out_d = fifo_data;
            byte_vld_d = 1'b1;
            sop_d      = 1'b1;
            req_cnt_d  = '0;
            cap_cnt_d  = '0;
        end

        if (state_q == StBody) begin
            if (rd_en) req_cnt_d = req_cnt_q + 7'd1;
            if (rd_d_q) begin
                byte_out_d = fifo_data;
                byte_vld_d = 1'b1;
                cap_cnt_d  = cap_cnt_q + 7'd1;
                if (last_cap) begin
                    eop_d        = 1'b1;
                    parity_err_d = (xor_q != fifo_data);
                end else begin
                    xor_d = xor_q ^ fifo_data;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_d_q       <= 1'b0;
            len_q        <= '0;
            addr_q       <= '0;
            xor_q        <= '0;
            req_cnt_q    <= '0;
            cap_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            byte_out_q   <= '0;
            byte_vld_q   <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            rd_d_q       <= rd_en;
            len_q        <= len_d;
            addr_q       <= addr_d;
            xor_q        <= xor_d;
            req_cnt_q    <= req_cnt_d;
            cap_cnt_q    <= cap_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            byte_out_q   <= byte_out_d;
            byte_vld_q   <= byte_vld_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_vld   = byte_vld_q;
    assign sop        = sop_q;
    assign eop        = eop_q;
    assign pkt_addr   = addr_q;
    assign pkt_len    = len_q;
    assign parity_err = parity_err_q;

`ifdef ROUTER_DRAIN_STATS_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [15:0] tmo_tot_q, tmo_tot_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        err_cnt_d = err_cnt_q;
        tmo_tot_d = tmo_tot_q;
        if (pkt_done && pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
        if (pkt_done && parity_err && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        if (soft_reset_out && tmo_tot_q != 16'hFFFF) tmo_tot_d = tmo_tot_q + 16'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
            tmo_tot_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
            tmo_tot_q <= tmo_tot_d;
        end
    end

    assign pkt_cnt       = pkt_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign tmo_cnt_total = tmo_tot_q;
`endif

endmodule

// File: tb/tb_router_pkt_drain.sv
// Directed bench for router_pkt_drain with a queue-based FIFO model.
module tb_router_pkt_drain;

    logic       clock = 1'b0;
    logic       reset;
    logic       empty;
    logic [7:0] fifo_data;
    logic       dst_ready;
    logic       rd_en, byte_vld, sop, eop, pkt_done, parity_err, soft_reset_out;
    logic [7:0] byte_out;
    logic [1:0] pkt_addr;
    logic [5:0] pkt_len;
`ifdef ROUTER_DRAIN_STATS_EN
    logic [15:0] pkt_cnt, err_cnt, tmo_cnt_total;
`endif

    router_pkt_drain dut (
        .clock          (clock),
        .reset          (reset),
        .empty          (empty),
        .fifo_data      (fifo_data),
        .dst_ready      (dst_ready),
        .rd_en          (rd_en),
        .byte_vld       (byte_vld),
        .byte_out       (byte_out),
        .sop            (sop),
        .eop            (eop),
        .pkt_addr       (pkt_addr),
        .pkt_len        (pkt_len),
        .pkt_done       (pkt_done),
        .parity_err     (parity_err),
        .soft_reset_out (soft_reset_out)
`ifdef ROUTER_DRAIN_STATS_EN
        ,
        .pkt_cnt        (pkt_cnt),
        .err_cnt        (err_cnt),
        .tmo_cnt_total  (tmo_cnt_total)
`endif
    );

    always #5 clock = ~clock;

    logic [7:0] fq[$];
    always @(posedge clock) begin
        if (rd_en && fq.size() > 0) begin
            fifo_data <= fq.pop_front();
            empty     <= (fq.size() == 0);
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_vld_cyc = 0;
    int rd_cnt, done_cnt, viol, srst_cnt, srst_gap;
    logic last_perr;
    logic [9:0] out_q[$];
    logic [9:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        cyc++;
        if (byte_vld) begin
            out_q.push_back({sop, eop, byte_out});
            last_vld_cyc = cyc;
        end
        if (rd_en) rd_cnt++;
        if (rd_en && (empty || !dst_ready)) viol++;
        if (pkt_done) begin
            done_cnt++;
            last_perr = parity_err;
        end
        if (soft_reset_out) begin
            srst_cnt++;
            srst_gap = cyc - last_vld_cyc;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        sample();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_mon();
        out_q.delete();
        exp_q.delete();
        rd_cnt = 0; done_cnt = 0; viol = 0; srst_cnt = 0; srst_gap = -1; last_perr = 1'bx;
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        empty = 1'b0;
    endtask

    task automatic expect_byte(input logic s, input logic e, input logic [7:0] b);
        exp_q.push_back({s, e, b});
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, "_count"}, out_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), {22'd0, out_q[i]}, {22'd0, exp_q[i]});
    endtask

    initial begin
        reset = 1'b1; empty = 1'b1; dst_ready = 1'b0; fifo_data = 8'h00;
        clear_mon();
        tick(); tick();
        chk("rst_byte_vld", byte_vld, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_parity_err", parity_err, 0);
        chk("rst_soft_reset", soft_reset_out, 0);
        chk("rst_len_addr", {pkt_len, pkt_addr}, 0);
        reset = 1'b0;
        tick();

        // Good packet: len 4, addr 1, parity 0x77
        clear_mon();
        dst_ready = 1'b1;
        push(8'h11); push(8'hA5); push(8'h3C); push(8'h0F); push(8'hF0); push(8'h77);
        expect_byte(1, 0, 8'h11); expect_byte(0, 0, 8'hA5); expect_byte(0, 0, 8'h3C);
        expect_byte(0, 0, 8'h0F); expect_byte(0, 0, 8'hF0); expect_byte(0, 1, 8'h77);
        repeat (25) tick();
        chk_stream("t1");
        chk("t1_done", done_cnt, 1);
        chk("t1_perr", last_perr, 0);
        chk("t1_len", pkt_len, 4);
        chk("t1_addr", pkt_addr, 1);
        chk("t1_rd_pulses", rd_cnt, 6);
        chk("t1_viol", viol, 0);

        // Bad parity
        clear_mon();
        push(8'h11); push(8'hA5); push(8'h3C); push(8'h0F); push(8'hF0); push(8'h76);
        repeat (25) tick();
        chk("t2_done", done_cnt, 1);
        chk("t2_perr", last_perr, 1);
        chk("t2_perr_held", parity_err, 1);

        // Zero-length packet
        clear_mon();
        push(8'h02); push(8'h02);
        expect_byte(1, 0, 8'h02); expect_byte(0, 1, 8'h02);
        repeat (15) tick();
        chk_stream("t3");
        chk("t3_done", done_cnt, 1);
        chk("t3_perr", last_perr, 0);
        chk("t3_len", pkt_len, 0);
        chk("t3_addr", pkt_addr, 2);

        // Truncated packet -> timeout
        clear_mon();
        push(8'h11); push(8'hAA); push(8'hBB);
        expect_byte(1, 0, 8'h11); expect_byte(0, 0, 8'hAA); expect_byte(0, 0, 8'hBB);
        repeat (50) tick();
        chk_stream("t4");
        chk("t4_srst_cnt", srst_cnt, 1);
        chk("t4_srst_gap", srst_gap, 29);
        chk("t4_no_done", done_cnt, 0);
        clear_mon();
        push(8'h02); push(8'h02);
        expect_byte(1, 0, 8'h02); expect_byte(0, 1, 8'h02);
        repeat (15) tick();
        chk_stream("t4b");
        chk("t4b_done", done_cnt, 1);

        // dst_ready toggling every cycle; parity 0x7C
        clear_mon();
        push(8'h0C); push(8'h12); push(8'h34); push(8'h56); push(8'h7C);
        expect_byte(1, 0, 8'h0C); expect_byte(0, 0, 8'h12); expect_byte(0, 0, 8'h34);
        expect_byte(0, 0, 8'h56); expect_byte(0, 1, 8'h7C);
        for (int i = 0; i < 40; i++) begin
            dst_ready = ~dst_ready;
            tick();
        end
        dst_ready = 1'b1;
        tick();
        chk_stream("t5");
        chk("t5_rd_pulses", rd_cnt, 5);
        chk("t5_viol", viol, 0);
        chk("t5_perr", last_perr, 0);
        chk("t5_done", done_cnt, 1);

        // Reset after the third byte of the first of two packets
        clear_mon();
        push(8'h08); push(8'h01); push(8'h02); push(8'h0B);
        push(8'h07); push(8'h55); push(8'h52);
        for (int i = 0; i < 20; i++) begin
            if (out_q.size() >= 3) break;
            tick();
        end
        chk("t6_reached3", out_q.size() >= 3, 1);
        reset = 1'b1;
        fq.delete();
        empty = 1'b1;
        #1;
        chk("t6_rst_byte_vld", byte_vld, 0);
        chk("t6_rst_out", {sop, eop, byte_out, pkt_len, pkt_addr}, 0);
        chk("t6_rst_flags", {rd_en, pkt_done, parity_err, soft_reset_out}, 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        clear_mon();
        push(8'h07); push(8'h55); push(8'h52);
        expect_byte(1, 0, 8'h07); expect_byte(0, 0, 8'h55); expect_byte(0, 1, 8'h52);
        repeat (15) tick();
        chk_stream("t6");
        chk("t6_done", done_cnt, 1);
        chk("t6_perr", last_perr, 0);
        chk("t6_len_addr", {pkt_len, pkt_addr}, {6'd1, 2'd3});
`ifdef ROUTER_DRAIN_STATS_EN
        chk("t6_pkt_cnt", pkt_cnt, 1);
        chk("t6_err_cnt", err_cnt, 0);
        chk("t6_tmo_total", tmo_cnt_total, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
